// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Purpose : Shared constants and types for the 7-segment scan decoder.
//           Segment encodings (bit7 = a .. bit1 = g, bit0 = dp), active-low
//           one-cold digit-select codes, dp bit index and the frame FSM
//           state type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Segment patterns for BCD 0..9, shown with dp = 0
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hF6;

  // Digit select, active-low one-cold
  localparam logic [3:0] CTRL_D0    = 4'b0111;  // units
  localparam logic [3:0] CTRL_D1    = 4'b1011;  // tens
  localparam logic [3:0] CTRL_D2    = 4'b1101;  // hundreds
  localparam logic [3:0] CTRL_D3    = 4'b1110;  // thousands
  localparam logic [3:0] CTRL_BLANK = 4'b1111;

  // Decimal point position inside the segment byte
  localparam int SEG_DP_BIT = 0;

  typedef enum logic [0:0] {
    FRAME_IDLE    = 1'b0,
    FRAME_COLLECT = 1'b1
  } frame_state_e;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pattern_decode
// Purpose : Combinational map from a 7-bit segment pattern (a..g) to its
//           BCD value plus a legal flag. Illegal patterns return 0 with
//           legal_o low.
// Ports   : pattern_i [6:0] - segments a (bit6) .. g (bit0)
//           bcd_o     [3:0] - decoded value, valid when legal_o = 1
//           legal_o         - pattern is one of the ten digit shapes
// Revision: 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] bcd_o,
  output logic       legal_o
);

  // Re-append a zero dp so the package byte constants compare directly
  logic [7:0] pattern_byte;
  assign pattern_byte = {pattern_i, 1'b0};

  always_comb begin
    bcd_o   = 4'd0;
    legal_o = 1'b1;
    case (pattern_byte)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: legal_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_decoder
// Purpose : Receive side of the multiplexed 4-digit 7-segment driver.
//           Registers ctrl/segment, waits for the pair to settle, decodes
//           the pattern back to BCD and rebuilds the four digits. Reports
//           frame completion, illegal patterns/selects and loss of scanning.
// Ports   : clk, rst         - clock, synchronous active-high reset
//           ctrl_i    [3:0]  - active-low one-cold digit select
//           segment_i [7:0]  - a..g on bits 7:1, dp on bit 0 (ignored)
//           digit0_o..digit3_o [3:0] - units .. thousands
//           digit_ok_o [3:0] - last capture of digit n was legal
//           frame_valid_o    - last completed frame had four legal digits
//           frame_stb_o      - 1-cycle pulse on frame completion
//           err_pulse_o      - 1-cycle pulse on illegal pattern or ctrl
//           stale_o          - no capture for TIMEOUT cycles
// Revision: 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ctrl_i,
  input  logic [7:0] segment_i,
  output logic [3:0] digit0_o,
  output logic [3:0] digit1_o,
  output logic [3:0] digit2_o,
  output logic [3:0] digit3_o,
  output logic [3:0] digit_ok_o,
  output logic       frame_valid_o,
  output logic       frame_stb_o,
  output logic       err_pulse_o,
  output logic       stale_o
);

  localparam int              CNT_W      = $clog2(SETTLE + 1);
  localparam int              TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_PRE = CNT_W'(SETTLE - 1);
  localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_PRE    = TMO_W'(TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Input register and counters
  // --------------------------------------------------------------------------
  logic [3:0]       ctrl_q;
  logic [7:0]       seg_q;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Pins equal the registered pair: the registered pair will not change at
  // this edge, so the dwell continues.
  logic pair_stable;
  assign pair_stable = (ctrl_i == ctrl_q) && (segment_i == seg_q);

  // Fires exactly once per dwell: the edge on which the counter reaches
  // SETTLE. Saturation keeps it from re-firing during a long dwell.
  logic fire;
  assign fire = pair_stable && (settle_q == SETTLE_PRE);

  always_comb begin
    settle_d = '0;
    if (pair_stable) begin
      settle_d = (settle_q == SETTLE_MAX) ? settle_q : settle_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Pattern and select classification
  // --------------------------------------------------------------------------
  logic [3:0] pat_bcd;
  logic       pat_legal;

  seg7_pattern_decode u_decode (
    .pattern_i (seg_q[7:1]),
    .bcd_o     (pat_bcd),
    .legal_o   (pat_legal)
  );

  logic [1:0] slot;
  logic       slot_valid;
  logic       ctrl_bad;

  always_comb begin
    slot       = 2'd0;
    slot_valid = 1'b1;
    ctrl_bad   = 1'b0;
    case (ctrl_q)
      CTRL_D0:    slot = 2'd0;
      CTRL_D1:    slot = 2'd1;
      CTRL_D2:    slot = 2'd2;
      CTRL_D3:    slot = 2'd3;
      CTRL_BLANK: slot_valid = 1'b0;
      default: begin
        slot_valid = 1'b0;
        ctrl_bad   = 1'b1;
      end
    endcase
  end

  logic       capture;
  logic       err_d;
  logic       tmo_hit;
  logic [3:0] slot_mask;
  logic [3:0] seen_q;
  logic [3:0] seen_nx;
  logic [3:0] digit_ok_q;
  logic [3:0] ok_nx;

  assign capture   = fire && slot_valid;
  assign err_d     = fire && (ctrl_bad || (slot_valid && !pat_legal));
  assign slot_mask = 4'b0001 << slot;
  assign seen_nx   = seen_q | slot_mask;
  // digit_ok including the capture happening at this edge
  assign ok_nx     = pat_legal ? (digit_ok_q | slot_mask) : (digit_ok_q & ~slot_mask);

  always_comb begin
    tmo_d = '0;
    if (!capture) begin
      tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
    end
  end

  // Counter reaches TIMEOUT at this edge with no capture to pre-empt it
  assign tmo_hit = !capture && (tmo_q == TMO_PRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= CTRL_BLANK;
      seg_q    <= 8'h00;
      settle_q <= '0;
      tmo_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_i;
      seg_q    <= segment_i;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM with registered outputs
  // --------------------------------------------------------------------------
  frame_state_e state_q;
  logic [3:0]   digit_q [4];
  logic         frame_valid_q;
  logic         frame_stb_q;
  logic         err_pulse_q;
  logic         stale_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FRAME_IDLE;
      seen_q        <= 4'b0000;
      digit_q[0]    <= 4'd0;
      digit_q[1]    <= 4'd0;
      digit_q[2]    <= 4'd0;
      digit_q[3]    <= 4'd0;
      digit_ok_q    <= 4'b0000;
      frame_valid_q <= 1'b0;
      frame_stb_q   <= 1'b0;
      err_pulse_q   <= 1'b0;
      stale_q       <= 1'b1;
    end else begin
      frame_stb_q <= 1'b0;
      err_pulse_q <= err_d;
      if (capture) begin
        stale_q    <= 1'b0;
        digit_ok_q <= ok_nx;
        if (pat_legal) begin
          digit_q[slot] <= pat_bcd;
        end
        case (state_q)
          FRAME_IDLE: begin
            seen_q  <= seen_nx;
            state_q <= FRAME_COLLECT;
          end
          FRAME_COLLECT: begin
            if (seen_nx == 4'b1111) begin
              frame_stb_q   <= 1'b1;
              frame_valid_q <= &ok_nx;
              seen_q        <= 4'b0000;
              state_q       <= FRAME_IDLE;
            end else begin
              // Repeated positions simply overwrite; seen is a set
              seen_q <= seen_nx;
            end
          end
          default: state_q <= FRAME_IDLE;
        endcase
      end else if (tmo_hit) begin
        stale_q       <= 1'b1;
        frame_valid_q <= 1'b0;
        seen_q        <= 4'b0000;
        state_q       <= FRAME_IDLE;
      end
    end
  end

  assign digit0_o      = digit_q[0];
  assign digit1_o      = digit_q[1];
  assign digit2_o      = digit_q[2];
  assign digit3_o      = digit_q[3];
  assign digit_ok_o    = digit_ok_q;
  assign frame_valid_o = frame_valid_q;
  assign frame_stb_o   = frame_stb_q;
  assign err_pulse_o   = err_pulse_q;
  assign stale_o       = stale_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_decoder
// Purpose : Self-checking bench for seg7_scan_decoder. A behavioural model
//           tracks run lengths of identical pin pairs, decodes by table
//           lookup and keeps the frame as a set of seen positions.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ctrl = 4'b1111;
  logic [7:0] seg = 8'h00;
  logic [3:0] digit0, digit1, digit2, digit3, digit_ok;
  logic       frame_valid, frame_stb, err_pulse, stale;

  seg7_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_i        (ctrl),
    .segment_i     (seg),
    .digit0_o      (digit0),
    .digit1_o      (digit1),
    .digit2_o      (digit2),
    .digit3_o      (digit3),
    .digit_ok_o    (digit_ok),
    .frame_valid_o (frame_valid),
    .frame_stb_o   (frame_stb),
    .err_pulse_o   (err_pulse),
    .stale_o       (stale)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]  pats [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                             8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
  logic [3:0]  m_dig [4];
  logic [3:0]  m_ok, m_seen;
  logic        m_fv, m_stale, e_stb, e_err;
  int          m_since, m_run;
  logic [11:0] m_last;
  int          exp_stb = 0, exp_err = 0, act_stb = 0, act_err = 0;

  function automatic int seg_value(input logic [7:0] s);
    for (int i = 0; i < 10; i++)
      if ({s[7:1], 1'b0} == pats[i]) return i;
    return -1;
  endfunction

  // Position of the single low bit: units is bit 3, thousands bit 0
  function automatic int ctrl_index(input logic [3:0] c);
    logic [3:0] inv;
    inv = ~c;
    if ($countones(inv) != 1) return -1;
    for (int n = 0; n < 4; n++)
      if (c[3-n] == 1'b0) return n;
    return -1;
  endfunction

  function automatic logic [21:0] m_vec();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_ok, m_fv, m_stale};
  endfunction

  task automatic model_step(input logic [3:0] c, input logic [7:0] s);
    int  n, v;
    logic cap_any;
    e_stb = 1'b0;
    e_err = 1'b0;
    cap_any = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
      m_ok = 4'b0000; m_seen = 4'b0000; m_fv = 1'b0; m_stale = 1'b1;
      m_since = 0; m_run = 1; m_last = {4'b1111, 8'h00};
    end else begin
      if ({c, s} == m_last) m_run++; else m_run = 1;
      m_last = {c, s};
      if (m_run == SETTLE + 1 && c != 4'b1111) begin
        n = ctrl_index(c);
        if (n < 0) e_err = 1'b1;
        else begin
          v = seg_value(s);
          cap_any = 1'b1;
          m_since = 0;
          m_stale = 1'b0;
          m_seen[n] = 1'b1;
          if (v < 0) begin m_ok[n] = 1'b0; e_err = 1'b1; end
          else begin m_dig[n] = 4'(v); m_ok[n] = 1'b1; end
          if (m_seen == 4'b1111) begin
            e_stb = 1'b1; m_fv = &m_ok; m_seen = 4'b0000;
          end
        end
      end
      if (!cap_any && m_since < TIMEOUT) begin
        m_since++;
        if (m_since == TIMEOUT) begin
          m_stale = 1'b1; m_fv = 1'b0; m_seen = 4'b0000;
        end
      end
    end
    if (e_stb) exp_stb++;
    if (e_err) exp_err++;
  endtask

  // One clock: drive at negedge, model at posedge, observe at next negedge
  task automatic cycle(input logic [3:0] c, input logic [7:0] s);
    ctrl = c;
    seg  = s;
    @(posedge clk);
    model_step(c, s);
    @(negedge clk);
    if (frame_stb) act_stb++;
    if (err_pulse) act_err++;
  endtask

  task automatic hold(input logic [3:0] c, input logic [7:0] s, input int n);
    repeat (n) cycle(c, s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hold(4'b1111, 8'h00, 3);
    rst = 1'b0;
    n_checks++;
    if ({digit3, digit2, digit1, digit0, digit_ok} !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_digits: got %h required 00000", {digit3, digit2, digit1, digit0, digit_ok});
    end
    n_checks++;
    if ({frame_valid, frame_stb, err_pulse, stale} !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_flags: got %b required 0001", {frame_valid, frame_stb, err_pulse, stale});
    end
  endtask

  task automatic test_frames();
    int s_stb, s_err;
    s_stb = act_stb; s_err = act_err;
    repeat (2) begin
      hold(4'b0111, 8'hF2, 10);
      hold(4'b1011, 8'h60, 10);
      hold(4'b1101, 8'hFC, 10);
      hold(4'b1110, 8'hB6, 10);
    end
    n_checks++;
    if ({digit3, digit2, digit1, digit0} !== 16'h5013) begin
      n_errors++;
      $display("FAIL frames_digits: got %h required 5013", {digit3, digit2, digit1, digit0});
    end
    n_checks++;
    if ({digit_ok, frame_valid, stale} !== 6'b111110) begin
      n_errors++;
      $display("FAIL frames_ok: got %b required 111110", {digit_ok, frame_valid, stale});
    end
    n_checks++;
    if (act_stb - s_stb !== 2 || act_err - s_err !== 0) begin
      n_errors++;
      $display("FAIL frames_pulses: stb %0d err %0d required 2 0", act_stb - s_stb, act_err - s_err);
    end
  endtask

  task automatic test_illegal_pattern();
    int s_stb, s_err;
    s_stb = act_stb; s_err = act_err;
    hold(4'b0111, 8'hF2, 10);
    hold(4'b1011, 8'h01, 10);
    hold(4'b1101, 8'hFC, 10);
    hold(4'b1110, 8'hB6, 10);
    n_checks++;
    if (act_err - s_err !== 1 || act_stb - s_stb !== 1) begin
      n_errors++;
      $display("FAIL illegal_pulses: err %0d stb %0d required 1 1", act_err - s_err, act_stb - s_stb);
    end
    n_checks++;
    if ({digit_ok, digit1, frame_valid} !== {4'b1101, 4'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL illegal_state: ok %b d1 %0d fv %b required 1101 1 0", digit_ok, digit1, frame_valid);
    end
  endtask

  task automatic test_glitch();
    hold(4'b1111, 8'h00, 5);
    hold(4'b0111, 8'hFC, 10);
    hold(4'b1111, 8'h00, 5);
    hold(4'b0111, 8'hDA, 2);
    hold(4'b1111, 8'h00, 5);
    n_checks++;
    if (digit0 !== 4'd0) begin
      n_errors++;
      $display("FAIL glitch_reject: digit0 %0d required 0", digit0);
    end
    hold(4'b0111, 8'hDA, 3);
    n_checks++;
    if (digit0 !== 4'd2) begin
      n_errors++;
      $display("FAIL glitch_capture: digit0 %0d required 2", digit0);
    end
    hold(4'b1111, 8'h00, 5);
  endtask

  task automatic test_bad_ctrl();
    logic [19:0] saved;
    int s_err;
    saved = {digit3, digit2, digit1, digit0, digit_ok};
    s_err = act_err;
    hold(4'b0011, 8'hF2, 10);
    n_checks++;
    if (act_err - s_err !== 1 || {digit3, digit2, digit1, digit0, digit_ok} !== saved) begin
      n_errors++;
      $display("FAIL bad_ctrl: err %0d state %h required 1 %h", act_err - s_err,
               {digit3, digit2, digit1, digit0, digit_ok}, saved);
    end
    hold(4'b1111, 8'hF2, 10);
    n_checks++;
    if (act_err - s_err !== 1) begin
      n_errors++;
      $display("FAIL blank_ctrl: err %0d required 1", act_err - s_err);
    end
    n_checks++;
    if (m_vec() !== {digit3, digit2, digit1, digit0, digit_ok, frame_valid, stale}) begin
      n_errors++;
      $display("FAIL bad_ctrl_model: got %h required %h",
               {digit3, digit2, digit1, digit0, digit_ok, frame_valid, stale}, m_vec());
    end
  endtask

  task automatic test_timeout();
    int rise;
    hold(4'b0111, 8'hFC, 10);
    hold(4'b1011, 8'h60, 10);
    hold(4'b1101, 8'hDA, 10);
    hold(4'b1110, 8'hF2, 10);
    n_checks++;
    if (frame_valid !== 1'b1 || stale !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_pre: fv %b stale %b required 1 0", frame_valid, stale);
    end
    rise = -1;
    for (int i = 1; i <= TIMEOUT + 10; i++) begin
      cycle(4'b1111, 8'h00);
      if (stale === 1'b1 && rise < 0) rise = i;
      n_checks++;
      if (stale !== m_stale) begin
        n_errors++;
        $display("FAIL timeout_stale_c%0d: got %b required %b", i, stale, m_stale);
      end
    end
    // Last capture was on the 3rd cycle of a 10-cycle dwell
    n_checks++;
    if (rise !== TIMEOUT - 7) begin
      n_errors++;
      $display("FAIL timeout_edge: rose at %0d required %0d", rise, TIMEOUT - 7);
    end
    n_checks++;
    if (stale !== 1'b1 || frame_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_post: stale %b fv %b required 1 0", stale, frame_valid);
    end
    hold(4'b1101, 8'h66, 10);
    n_checks++;
    if (stale !== 1'b0 || digit2 !== 4'd4) begin
      n_errors++;
      $display("FAIL timeout_clear: stale %b d2 %0d required 0 4", stale, digit2);
    end
  endtask

  task automatic test_reset_midframe();
    int s_stb;
    hold(4'b1111, 8'h00, TIMEOUT + 5);
    hold(4'b0111, 8'hE0, 10);
    hold(4'b1011, 8'hFE, 10);
    hold(4'b1111, 8'h00, 3);
    rst = 1'b1;
    cycle(4'b1111, 8'h00);
    rst = 1'b0;
    n_checks++;
    if ({digit3, digit2, digit1, digit0, digit_ok, frame_valid, frame_stb, err_pulse, stale}
        !== {20'h0, 4'b0001}) begin
      n_errors++;
      $display("FAIL midframe_reset: got %h required 000001",
               {digit3, digit2, digit1, digit0, digit_ok, frame_valid, frame_stb, err_pulse, stale});
    end
    s_stb = act_stb;
    hold(4'b0111, 8'hBE, 10);
    hold(4'b1011, 8'hF6, 10);
    hold(4'b1101, 8'h66, 10);
    hold(4'b1110, 8'h60, 10);
    n_checks++;
    if (act_stb - s_stb !== 1 || {digit3, digit2, digit1, digit0} !== 16'h1496) begin
      n_errors++;
      $display("FAIL midframe_frame: stb %0d digits %h required 1 1496",
               act_stb - s_stb, {digit3, digit2, digit1, digit0});
    end
  endtask

  task automatic test_random();
    logic [3:0] c;
    logic [7:0] s;
    logic [3:0] sel [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    int r, len;
    for (int k = 0; k < 160; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) c = sel[$urandom_range(0, 3)];
      else if (r <= 7) c = 4'b1111;
      else c = 4'($urandom);
      if ($urandom_range(0, 9) < 8) s = pats[$urandom_range(0, 9)];
      else s = 8'($urandom);
      s[0] = 1'($urandom);
      len = ($urandom_range(0, 29) == 0) ? TIMEOUT + 6 : $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        cycle(c, s);
        n_checks++;
        if ({frame_stb, err_pulse} !== {e_stb, e_err} ||
            {digit3, digit2, digit1, digit0, digit_ok, frame_valid, stale} !== m_vec()) begin
          n_errors++;
          $display("FAIL random_d%0d_c%0d: got %b %b %h required %b %b %h", k, j, frame_stb,
                   err_pulse, {digit3, digit2, digit1, digit0, digit_ok, frame_valid, stale},
                   e_stb, e_err, m_vec());
        end
      end
    end
    n_checks++;
    if (act_stb !== exp_stb || act_err !== exp_err) begin
      n_errors++;
      $display("FAIL pulse_totals: stb %0d err %0d required %0d %0d", act_stb, act_err, exp_stb, exp_err);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frames();
    test_illegal_pattern();
    test_glitch();
    test_bad_ctrl();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
